// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring pattern decoder.
package ring_pkg;

  // Lock state of the decoder.
  typedef enum logic [1:0] {
    HUNT,
    TRACK,
    LOCKED
  } state_t;

  // Classification of one sample relative to the previous one.
  typedef enum logic [2:0] {
    NONE,
    UP,
    DN,
    HOLD,
    JUMP,
    BAD
  } step_t;

  // Both ring neighbours of an index.
  typedef struct packed {
    logic [31:0] up;
    logic [31:0] dn;
  } nbr_t;

  // Returns (idx+1) mod width and (idx-1) mod width without a divider.
  function automatic nbr_t ring_neighbours(input logic [31:0] idx,
                                           input logic [31:0] width);
    nbr_t n;
    n.up = (idx == width - 32'd1) ? 32'd0 : idx + 32'd1;
    n.dn = (idx == 32'd0) ? width - 32'd1 : idx - 32'd1;
    return n;
  endfunction

endpackage

// File: rtl/onehot_index.sv
// Combinational one-hot checker: flags words with exactly one bit set
// and returns the position of the highest set bit.
module onehot_index #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         in,
  output logic                     legal,
  output logic [$clog2(WIDTH)-1:0] idx
);

  localparam int IW = $clog2(WIDTH);

  logic [IW:0] w_cnt;

  // Population count and bit position in a single scan.
  always_comb begin
    w_cnt = '0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) begin
        w_cnt = w_cnt + 1'b1;
        idx   = IW'(i);
      end
    end
    legal = (w_cnt == (IW + 1)'(1));
  end

endmodule

// File: rtl/ring_pattern_decoder.sv
// Receive-side decoder for a rotating one-hot ring word: decodes the
// active position, locks onto a steady rotation direction, flags bad
// steps while locked and counts full revolutions.
module ring_pattern_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int MISS_LIMIT = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     pos_valid,
  output logic                     dir,
  output logic                     locked,
  output logic                     err,
  output logic                     rev_pulse,
  output logic [CNT_W-1:0]         rev_count
);

  localparam int IW     = $clog2(WIDTH);
  localparam int TRK_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  // Current sample decode.
  logic          w_cur_legal;
  logic [IW-1:0] w_cur_idx;

  // Previous sample, updated every edge whether legal or not.
  logic          r_last_legal;
  logic [IW-1:0] r_last_idx;

  // Control state.
  state_t           r_state;
  logic [TRK_W-1:0] r_trk_cnt;
  logic             r_cand_dir;
  logic [MISS_W-1:0] r_miss;

  // Registered outputs.
  logic [IW-1:0]    r_pos;
  logic             r_pos_valid;
  logic             r_dir;
  logic             r_locked;
  logic             r_err;
  logic             r_rev_pulse;
  logic [CNT_W-1:0] r_rev_count;

  // Next-state values.
  step_t             w_step;
  nbr_t              w_nbr;
  logic              w_step_up;
  logic              w_in_dir;
  state_t            w_state_nxt;
  logic [TRK_W-1:0]  w_trk_nxt;
  logic [TRK_W-1:0]  w_trk_step;
  logic              w_cand_nxt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic [MISS_W-1:0] w_miss_step;
  logic              w_dir_nxt;
  logic              w_err_nxt;
  logic              w_rev_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  onehot_index #(
    .WIDTH(WIDTH)
  ) u_cur_idx (
    .in   (in),
    .legal(w_cur_legal),
    .idx  (w_cur_idx)
  );

  // Classify the step from the previous sample to the current one.
  always_comb begin
    w_nbr = ring_neighbours(32'(r_last_idx), 32'(WIDTH));
    if (!w_cur_legal)
      w_step = BAD;
    else if (!r_last_legal)
      w_step = NONE;
    else if (w_cur_idx == r_last_idx)
      w_step = HOLD;
    else if (32'(w_cur_idx) == w_nbr.up)
      w_step = UP;
    else if (32'(w_cur_idx) == w_nbr.dn)
      w_step = DN;
    else
      w_step = JUMP;
  end

  // Lock FSM next state plus err/revolution bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_trk_nxt   = r_trk_cnt;
    w_trk_step  = r_trk_cnt;
    w_cand_nxt  = r_cand_dir;
    w_miss_nxt  = r_miss;
    w_miss_step = r_miss + MISS_W'(1);
    w_dir_nxt   = r_dir;
    w_err_nxt   = 1'b0;
    w_rev_nxt   = 1'b0;
    w_cnt_nxt   = r_rev_count;
    w_step_up   = (w_step == UP);
    w_in_dir    = (w_step == UP && r_dir) || (w_step == DN && !r_dir);

    case (r_state)
      HUNT: begin
        if (w_cur_legal) begin
          w_state_nxt = TRACK;
          w_trk_nxt   = '0;
        end
      end

      TRACK: begin
        case (w_step)
          BAD: begin
            w_state_nxt = HUNT;
            w_trk_nxt   = '0;
          end
          UP, DN: begin
            // A fresh run or a direction reversal restarts the count at 1.
            if (r_trk_cnt == '0 || w_step_up != r_cand_dir) begin
              w_cand_nxt = w_step_up;
              w_trk_step = TRK_W'(1);
            end else begin
              w_trk_step = r_trk_cnt + TRK_W'(1);
            end
            if (w_trk_step == TRK_W'(LOCK_COUNT)) begin
              w_state_nxt = LOCKED;
              w_dir_nxt   = w_cand_nxt;
              w_miss_nxt  = '0;
              w_trk_nxt   = '0;
            end else begin
              w_trk_nxt = w_trk_step;
            end
          end
          default: w_trk_nxt = '0;
        endcase
      end

      LOCKED: begin
        if (w_in_dir) begin
          w_miss_nxt = '0;
          if (w_cur_idx == '0) begin
            w_rev_nxt = 1'b1;
            w_cnt_nxt = r_rev_count + CNT_W'(1);
          end
        end else if (w_step != NONE) begin
          // A legal word right after an illegal one has no step to judge,
          // so it neither counts as a miss nor clears one.
          w_err_nxt = 1'b1;
          if (w_miss_step == MISS_W'(MISS_LIMIT)) begin
            w_state_nxt = HUNT;
            w_miss_nxt  = '0;
            w_trk_nxt   = '0;
          end else begin
            w_miss_nxt = w_miss_step;
          end
        end
      end

      default: w_state_nxt = HUNT;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_last_legal <= 1'b0;
      r_last_idx   <= '0;
      r_trk_cnt    <= '0;
      r_cand_dir   <= 1'b0;
      r_miss       <= '0;
      r_pos        <= '0;
      r_pos_valid  <= 1'b0;
      r_dir        <= 1'b0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
      r_rev_pulse  <= 1'b0;
      r_rev_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_legal <= w_cur_legal;
      r_last_idx   <= w_cur_idx;
      r_trk_cnt    <= w_trk_nxt;
      r_cand_dir   <= w_cand_nxt;
      r_miss       <= w_miss_nxt;
      r_pos        <= w_cur_legal ? w_cur_idx : '0;
      r_pos_valid  <= w_cur_legal;
      r_dir        <= w_dir_nxt;
      r_locked     <= (w_state_nxt == LOCKED);
      r_err        <= w_err_nxt;
      r_rev_pulse  <= w_rev_nxt;
      r_rev_count  <= w_cnt_nxt;
    end
  end

  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;
  assign dir       = r_dir;
  assign locked    = r_locked;
  assign err       = r_err;
  assign rev_pulse = r_rev_pulse;
  assign rev_count = r_rev_count;

endmodule
